// File: rtl/mem_port_arbiter_if.sv
// mem_port_arbiter_if
//   Bundles the requester-side and memory-side signals of the memory port arbiter.
//   master : cache controllers plus the memory model (drive requests and MRData)
//   slave  : the arbiter itself (drives grants, ready pulses and the memory bus)
// Signals
//   RStrobe[1:0]   per-requester request, held until that requester's RReady
//   RRW[1:0]       per-requester 1=read 0=write
//   RAddr0/1       requester addresses
//   RWData0/1      requester write data
//   RRData         registered read data, valid in the RReady cycle
//   RReady[1:0]    one-cycle completion pulse to the granted requester
//   Grant[1:0]     one-hot owner of the memory port, 00 when idle
//   MStrobe        one-cycle memory strobe per access
//   MRW            memory 1=read 0=write
//   MAddr          memory address
//   MWData         memory write data
//   MDataOE        write data output enable, high for a whole write access
//   MRData         memory read data
interface mem_port_arbiter_if #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
);
   logic [1:0]        RStrobe;
   logic [1:0]        RRW;
   logic [ADDR_W-1:0] RAddr0;
   logic [ADDR_W-1:0] RAddr1;
   logic [DATA_W-1:0] RWData0;
   logic [DATA_W-1:0] RWData1;
   logic [DATA_W-1:0] RRData;
   logic [1:0]        RReady;
   logic [1:0]        Grant;
   logic              MStrobe;
   logic              MRW;
   logic [ADDR_W-1:0] MAddr;
   logic [DATA_W-1:0] MWData;
   logic              MDataOE;
   logic [DATA_W-1:0] MRData;

   modport master (
      output RStrobe, RRW, RAddr0, RAddr1, RWData0, RWData1, MRData,
      input  RRData, RReady, Grant, MStrobe, MRW, MAddr, MWData, MDataOE
   );

   modport slave (
      input  RStrobe, RRW, RAddr0, RAddr1, RWData0, RWData1, MRData,
      output RRData, RReady, Grant, MStrobe, MRW, MAddr, MWData, MDataOE
   );
endinterface

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//   Shares one main-memory port between requester 0 (I-side cache) and
//   requester 1 (D-side cache). Memory has no ready line, so each access is
//   timed by an internal wait-state counter: STROBE -> WAIT... -> DONE -> IDLE.
//   Ties are broken in favour of the requester that was not granted last.
// Ports
//   Clk    clock, all state updates on the rising edge
//   Reset  synchronous, active-high
//   bus    mem_port_arbiter_if.slave (requester and memory signals)
// Parameters
//   ADDR_W, DATA_W     bus widths (must match the interface instance)
//   RD_WAIT, WR_WAIT   memory read/write latency in cycles from MStrobe (>=1)
// Configuration
//   ARB_STATS_EN  when defined, adds saturating 32-bit counters NGrant0,
//                 NGrant1 and NStall, readable hierarchically. Ports and
//                 timing are identical either way.
module mem_port_arbiter #(
   parameter int ADDR_W  = 32,
   parameter int DATA_W  = 32,
   parameter int RD_WAIT = 4,
   parameter int WR_WAIT = 4
) (
   input  logic           Clk,
   input  logic           Reset,
   mem_port_arbiter_if.slave bus
);

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_STROBE = 2'd1,
      ST_WAIT   = 2'd2,
      ST_DONE   = 2'd3
   } state_t;

   // Counter load values: the STROBE cycle itself counts as the first wait cycle.
   localparam logic [15:0] RD_LOAD = 16'(RD_WAIT - 1);
   localparam logic [15:0] WR_LOAD = 16'(WR_WAIT - 1);

   state_t            state;
   state_t            next_state;
   logic [1:0]        grant_q;
   logic              last_grant;
   logic [15:0]       count;
   logic              mrw_q;
   logic [ADDR_W-1:0] maddr_q;
   logic [DATA_W-1:0] mwdata_q;
   logic [DATA_W-1:0] rrdata_q;
   logic [1:0]        win;

   // Winner selection while idle: a lone requester wins outright; on a tie the
   // requester that did not own the port last time wins, so grants alternate.
   always_comb begin
      win = 2'b00;
      unique case (bus.RStrobe)
         2'b01:   win = 2'b01;
         2'b10:   win = 2'b10;
         2'b11:   win = last_grant ? 2'b01 : 2'b10;
         default: win = 2'b00;
      endcase
   end

   // State register.
   always_ff @(posedge Clk) begin
      if (Reset) begin
         state <= ST_IDLE;
      end else begin
         state <= next_state;
      end
   end

   // Next-state logic. A zero load (one-cycle latency) skips WAIT entirely.
   always_comb begin
      next_state = state;
      unique case (state)
         ST_IDLE:   if (|bus.RStrobe) next_state = ST_STROBE;
         ST_STROBE: next_state = ((mrw_q ? RD_LOAD : WR_LOAD) == 16'd0) ? ST_DONE : ST_WAIT;
         ST_WAIT:   if (count <= 16'd1) next_state = ST_DONE;
         ST_DONE:   next_state = ST_IDLE;
         default:   next_state = ST_IDLE;
      endcase
   end

   // Access datapath. The winner's direction, address and data are captured
   // on the grant edge, so later requester changes cannot disturb the access.
   // Read data is captured on the edge entering DONE so it is valid alongside RReady.
   always_ff @(posedge Clk) begin
      if (Reset) begin
         grant_q    <= 2'b00;
         last_grant <= 1'b1;
         count      <= 16'd0;
         mrw_q      <= 1'b1;
         maddr_q    <= '0;
         mwdata_q   <= '0;
         rrdata_q   <= '0;
      end else begin
         unique case (state)
            ST_IDLE: begin
               if (|bus.RStrobe) begin
                  grant_q  <= win;
                  mrw_q    <= win[1] ? bus.RRW[1] : bus.RRW[0];
                  maddr_q  <= win[1] ? bus.RAddr1 : bus.RAddr0;
                  mwdata_q <= win[1] ? bus.RWData1 : bus.RWData0;
               end
            end
            ST_STROBE: count <= mrw_q ? RD_LOAD : WR_LOAD;
            ST_WAIT:   if (count != 16'd0) count <= count - 16'd1;
            ST_DONE: begin
               last_grant <= grant_q[1];
               grant_q    <= 2'b00;
            end
            default: grant_q <= 2'b00;
         endcase
         if ((next_state == ST_DONE) && (state != ST_DONE) && mrw_q) begin
            rrdata_q <= bus.MRData;
         end
      end
   end

   // Outputs decoded from the state and captured access registers.
   always_comb begin
      bus.Grant   = grant_q;
      bus.MStrobe = (state == ST_STROBE);
      bus.RReady  = (state == ST_DONE) ? grant_q : 2'b00;
      bus.MRW     = mrw_q;
      bus.MAddr   = maddr_q;
      bus.MWData  = mwdata_q;
      bus.MDataOE = (state != ST_IDLE) && !mrw_q;
      bus.RRData  = rrdata_q;
   end

`ifdef ARB_STATS_EN
   logic [31:0] NGrant0;
   logic [31:0] NGrant1;
   logic [31:0] NStall;

   // Saturating usage counters. A stall cycle is any cycle where some
   // requester is asserting but does not currently own the port.
   always_ff @(posedge Clk) begin
      if (Reset) begin
         NGrant0 <= 32'd0;
         NGrant1 <= 32'd0;
         NStall  <= 32'd0;
      end else begin
         if ((state == ST_IDLE) && win[0] && (NGrant0 != 32'hFFFF_FFFF)) NGrant0 <= NGrant0 + 32'd1;
         if ((state == ST_IDLE) && win[1] && (NGrant1 != 32'hFFFF_FFFF)) NGrant1 <= NGrant1 + 32'd1;
         if ((|(bus.RStrobe & ~grant_q)) && (NStall != 32'hFFFF_FFFF)) NStall <= NStall + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter
//   Drives two cache requesters and a memory model against mem_port_arbiter.
//   A transaction-level reference model predicts, per cycle, the grant owner,
//   strobe, ready pulse and bus contents from the arbitration rules and the
//   fixed access latency. A second instance with one-cycle latency covers
//   the STROBE-to-DONE shortcut.
module tb_mem_port_arbiter;
   localparam int AW  = 32;
   localparam int DW  = 32;
   localparam int RDW = 4;
   localparam int WRW = 4;

   logic Clk = 1'b0;
   logic Reset;
   always #5 Clk = ~Clk;

   mem_port_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();
   mem_port_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus2 ();

   mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .RD_WAIT(RDW), .WR_WAIT(WRW)) dut (
      .Clk(Clk), .Reset(Reset), .bus(bus)
   );
   mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .RD_WAIT(1), .WR_WAIT(1)) dut2 (
      .Clk(Clk), .Reset(Reset), .bus(bus2)
   );

   int checks = 0;
   int errors = 0;
   int cyc = 0;

   // Requester intentions
   bit          req[2];
   bit          rw[2];
   logic [31:0] addr[2];
   logic [31:0] wdata[2];

   // Reference model state
   bit          busy, cur_idle, rst_prev, lastg, scramble_en;
   int          owner, t_start, wlen;
   bit          m_rd;
   logic [31:0] m_addr, m_wdata, m_mem, exp_rrdata;
   int          done_q[$];
   int          done_cyc[$];

   task automatic check(string tag, logic [63:0] obs, logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // One clock cycle: decide what the coming edge samples, drive, then check
   // the following cycle against the model.
   task automatic step();
      int ph;
      logic [1:0] eg, er;
      if (!Reset && cur_idle && (req[0] || req[1])) begin
         if (req[0] && req[1]) owner = lastg ? 0 : 1;
         else                  owner = req[1] ? 1 : 0;
         m_rd    = rw[owner];
         m_addr  = addr[owner];
         m_wdata = wdata[owner];
         wlen    = m_rd ? RDW : WRW;
         t_start = cyc + 1;
         busy    = 1'b1;
      end
      bus.RStrobe = {req[1], req[0]};
      bus.RRW     = {rw[1], rw[0]};
      bus.RAddr0  = addr[0];
      bus.RAddr1  = addr[1];
      bus.RWData0 = wdata[0];
      bus.RWData1 = wdata[1];
      rst_prev    = Reset;
      @(posedge Clk);
      #1;
      cyc++;
      if (rst_prev) begin
         busy = 1'b0;
         lastg = 1'b1;
         exp_rrdata = '0;
      end
      cur_idle = !busy;
      ph = cyc - t_start;
      eg = busy ? 2'(1 << owner) : 2'b00;
      er = (busy && ph == wlen) ? eg : 2'b00;
      if (busy && ph == 0) begin
         m_mem = $urandom;
         bus.MRData = m_mem;
      end
      if (busy && ph == wlen && m_rd) exp_rrdata = m_mem;
      check("grant", bus.Grant, eg);
      check("mstrobe", bus.MStrobe, busy && ph == 0);
      check("rready", bus.RReady, er);
      check("mdataoe", bus.MDataOE, busy && !m_rd);
      check("rrdata", bus.RRData, exp_rrdata);
      if (rst_prev) begin
         check("maddr_rst", bus.MAddr, 0);
         check("mrw_rst", bus.MRW, 1);
      end
      if (busy) begin
         check("mrw", bus.MRW, m_rd);
         check("maddr", bus.MAddr, m_addr);
         if (!m_rd) check("mwdata", bus.MWData, m_wdata);
      end
      if (busy && ph == wlen) begin
         req[owner] = 1'b0;
         lastg = owner[0];
         busy = 1'b0;
         done_q.push_back(owner);
         done_cyc.push_back(cyc);
      end else if (busy && scramble_en && $urandom_range(0, 1) == 1) begin
         addr[owner]  = $urandom;
         wdata[owner] = $urandom;
      end
   endtask

   task automatic wait_done(int n, int budget);
      int k = 0;
      while (done_q.size() < n && k < budget) begin
         step();
         k++;
      end
      check("done_timeout", done_q.size() >= n, 1);
   endtask

   initial begin
      int c0, k;
      logic [31:0] v2;
      Reset = 1'b1;
      for (int i = 0; i < 2; i++) begin
         req[i] = 1'b0; rw[i] = 1'b1; addr[i] = '0; wdata[i] = '0;
      end
      bus.MRData = '0;
      bus2.RStrobe = 2'b00; bus2.RRW = 2'b00; bus2.RAddr0 = '0; bus2.RAddr1 = '0;
      bus2.RWData0 = '0; bus2.RWData1 = '0; bus2.MRData = '0;
      busy = 0; cur_idle = 0; lastg = 1; exp_rrdata = '0; scramble_en = 0;

      // Reset held two cycles, no requests
      step();
      step();
      Reset = 1'b0;
      step();

      // Requester 0 read at 0x100
      done_q.delete(); done_cyc.delete();
      req[0] = 1; rw[0] = 1; addr[0] = 32'h100; wdata[0] = $urandom;
      c0 = cyc;
      wait_done(1, 20);
      check("t2_owner", done_q[0], 0);
      check("t2_ready_cycle", done_cyc[0], c0 + 1 + RDW);

      // Requester 1 write 0xDEADBEEF at 0x200
      step();
      done_q.delete(); done_cyc.delete();
      req[1] = 1; rw[1] = 0; addr[1] = 32'h200; wdata[1] = 32'hDEADBEEF;
      c0 = cyc;
      wait_done(1, 20);
      check("t3_owner", done_q[0], 1);
      check("t3_ready_cycle", done_cyc[0], c0 + 1 + WRW);

      // Both requesters continuously high: strict alternation
      done_q.delete(); done_cyc.delete();
      rw[0] = 1; rw[1] = 1;
      k = 0;
      while (done_q.size() < 4 && k < 60) begin
         req[0] = 1; req[1] = 1;
         step();
         k++;
      end
      req[0] = 0; req[1] = 0;
      check("t4_count", done_q.size(), 4);
      check("t4_order0", done_q[0], 0);
      check("t4_order1", done_q[1], 1);
      check("t4_order2", done_q[2], 0);
      check("t4_order3", done_q[3], 1);
      for (int i = 1; i < 4; i++) check("t4_gap", done_cyc[i] - done_cyc[i-1], RDW + 2);

      // Randomized traffic with address/data churn during accesses
      scramble_en = 1;
      for (int n = 0; n < 600; n++) begin
         for (int i = 0; i < 2; i++) begin
            if (!req[i] && $urandom_range(0, 3) == 0) begin
               req[i] = 1; rw[i] = $urandom_range(0, 1) == 1;
               addr[i] = $urandom; wdata[i] = $urandom;
            end
         end
         step();
      end
      scramble_en = 0;
      k = 0;
      while ((req[0] || req[1] || busy) && k < 100) begin
         step();
         k++;
      end
      check("drain", {req[1], req[0], busy}, 0);
      step();

      // Reset during WAIT of a requester 0 read, then requester 1 served
      req[0] = 1; rw[0] = 1; addr[0] = 32'h300;
      step();
      step();
      step();
      check("t5_in_wait", busy, 1);
      Reset = 1'b1; req[0] = 0;
      step();
      Reset = 1'b0;
      step();
      done_q.delete(); done_cyc.delete();
      req[1] = 1; rw[1] = 0; addr[1] = 32'h400; wdata[1] = 32'h1234_5678;
      wait_done(1, 20);
      check("t5_owner", done_q[0], 1);
      step();

      // One-cycle read latency instance: STROBE goes straight to DONE
      v2 = $urandom;
      bus2.RRW = 2'b01; bus2.RAddr0 = 32'h100; bus2.MRData = v2; bus2.RStrobe = 2'b01;
      step();
      check("t6_strobe", bus2.MStrobe, 1);
      check("t6_grant", bus2.Grant, 2'b01);
      check("t6_ready_early", bus2.RReady, 2'b00);
      check("t6_maddr", bus2.MAddr, 32'h100);
      step();
      check("t6_ready", bus2.RReady, 2'b01);
      check("t6_rrdata", bus2.RRData, v2);
      check("t6_strobe_off", bus2.MStrobe, 0);
      bus2.RStrobe = 2'b00;
      step();
      check("t6_grant_idle", bus2.Grant, 2'b00);
      check("t6_ready_off", bus2.RReady, 2'b00);
`ifdef ARB_STATS_EN
      check("t6_ngrant0", dut2.NGrant0, 1);
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
